// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, ibus handshake, instruction buffer.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        pipeline_nop_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_fo,
  output logic [31:0] pc_fo,
  output logic        inst_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] LIM = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_last_pc;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_disc_cnt;
  logic [CW-1:0] r_f_cnt;
  logic [PW-1:0] r_aq_wp;
  logic [PW-1:0] r_aq_rp;
  logic [PW-1:0] r_f_wp;
  logic [PW-1:0] r_f_rp;
  logic [31:0]   r_aq        [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_fifo_inst [FIFO_DEPTH];

  logic [CW:0]   w_used;
  logic          w_req;
  logic          w_fire;
  logic          w_drop;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic [CW-1:0] w_out_nxt;
  logic          w_unused;

  assign w_unused  = ^redirect_pc_i[1:0];
  assign w_used    = {1'b0, r_out_cnt} + {1'b0, r_f_cnt};
  assign w_req     = (r_state != S_BOOT) && (w_used < LIM);
  assign w_fire    = w_req & ibus_gnt_i;
  // Responses arriving with a redirect belong to the old path.
  assign w_drop    = ibus_rvalid_i & (redirect_i | (r_disc_cnt != '0));
  assign w_push    = ibus_rvalid_i & ~w_drop;
  assign w_valid   = (r_f_cnt != '0);
  assign w_pop     = w_valid & ~pipeline_nop_i;
  assign w_out_nxt = r_out_cnt + CW'(w_fire) - CW'(ibus_rvalid_i);

  assign ibus_req_o   = w_req;
  assign ibus_addr_o  = r_fetch_pc;
  assign inst_valid_o = w_valid;
  assign inst_fo      = w_valid ? r_fifo_inst[r_f_rp] : NOP;
  assign pc_fo        = w_valid ? r_fifo_pc[r_f_rp] : r_last_pc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_last_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_disc_cnt <= '0;
      r_f_cnt    <= '0;
      r_aq_wp    <= '0;
      r_aq_rp    <= '0;
      r_f_wp     <= '0;
      r_f_rp     <= '0;
    end else begin
      r_out_cnt <= w_out_nxt;
      if (w_pop) r_last_pc <= r_fifo_pc[r_f_rp];
      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        r_disc_cnt <= w_out_nxt;
        r_aq_wp    <= '0;
        r_aq_rp    <= '0;
        r_f_wp     <= '0;
        r_f_rp     <= '0;
        r_f_cnt    <= '0;
        r_state    <= (w_out_nxt != '0) ? S_DRAIN : S_RUN;
      end else begin
        if (w_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_aq_wp    <= r_aq_wp + PW'(1);
        end
        if (w_drop) r_disc_cnt <= r_disc_cnt - CW'(1);
        if (w_push) begin
          r_aq_rp <= r_aq_rp + PW'(1);
          r_f_wp  <= r_f_wp + PW'(1);
        end
        if (w_pop) r_f_rp <= r_f_rp + PW'(1);
        r_f_cnt <= r_f_cnt + CW'(w_push) - CW'(w_pop);
        unique case (r_state)
          S_BOOT:  r_state <= S_RUN;
          S_RUN:   r_state <= S_RUN;
          S_DRAIN: begin
            if (r_disc_cnt == '0 ||
                (r_disc_cnt == CW'(1) && ibus_rvalid_i))
              r_state <= S_RUN;
          end
          default: r_state <= S_BOOT;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!redirect_i && w_fire) r_aq[r_aq_wp] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_pc[r_f_wp]   <= r_aq[r_aq_rp];
      r_fifo_inst[r_f_wp] <= ibus_rdata_i;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_valid && pipeline_nop_i)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order ibus slave model.
// Slave returns rdata = ~addr; responses are gated by rsp_en.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        nop = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic [31:0] inst_fo;
  logic [31:0] pc_fo;
  logic        inst_valid_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic        rsp_en = 1'b0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ibus_req_o     (ibus_req_o),
    .ibus_addr_o    (ibus_addr_o),
    .ibus_gnt_i     (gnt),
    .ibus_rvalid_i  (rvalid),
    .ibus_rdata_i   (rdata),
    .pipeline_nop_i (nop),
    .redirect_i     (redir),
    .redirect_pc_i  (redir_pc),
    .inst_fo        (inst_fo),
    .pc_fo          (pc_fo),
    .inst_valid_o   (inst_valid_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o (perf_fetch),
    .perf_stall_cnt_o (perf_stall)
`endif
  );

  task automatic tick();
    logic        f;
    logic [31:0] a;
    f = ibus_req_o & gnt;
    a = ibus_addr_o;
    @(posedge clk);
    #1;
    if (f) q.push_back(a);
    if (rsp_en && q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = ~q.pop_front();
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    nop = 1'b0; redir = 1'b0; redir_pc = '0; rsp_en = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0 || inst_fo !== 32'h13 ||
        pc_fo !== 32'h0 || inst_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: req=%b addr=%h inst=%h pc=%h v=%b exp 0/0/13/0/0",
               ibus_req_o, ibus_addr_o, inst_fo, pc_fo, inst_valid_o);
    end
`ifdef FETCH_PERF_CNT_EN
    n_chk++;
    if (perf_fetch !== 32'h0 || perf_stall !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d/%0d exp 0/0", perf_fetch, perf_stall);
    end
`endif
  endtask

  task automatic test_basic();
    do_reset(); gnt = 1'b1; rsp_en = 1'b1;
    n_chk++;
    if (ibus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_boot: req=%b exp 0", ibus_req_o);
    end
    tick();
    n_chk++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL basic_c2: req=%b addr=%h exp 1/0", ibus_req_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h4 || inst_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_c3: req=%b addr=%h v=%b exp 1/4/0", ibus_req_o, ibus_addr_o, inst_valid_o);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b1 || pc_fo !== 32'h0 || inst_fo !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL basic_c4: v=%b pc=%h inst=%h exp 1/0/ffffffff", inst_valid_o, pc_fo, inst_fo);
    end
    tick();
    n_chk++;
    if (pc_fo !== 32'h4 || inst_fo !== 32'hFFFF_FFFB || ibus_req_o !== 1'b1 ||
        ibus_addr_o !== 32'h8) begin
      n_fail++;
      $display("FAIL basic_c5: pc=%h inst=%h req=%b addr=%h exp 4/fffffffb/1/8",
               pc_fo, inst_fo, ibus_req_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b0 || inst_fo !== 32'h13 || pc_fo !== 32'h4) begin
      n_fail++;
      $display("FAIL basic_empty: v=%b inst=%h pc=%h exp 0/13/4", inst_valid_o, inst_fo, pc_fo);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b1 || pc_fo !== 32'h8 || inst_fo !== 32'hFFFF_FFF7) begin
      n_fail++;
      $display("FAIL basic_c7: v=%b pc=%h inst=%h exp 1/8/fffffff7", inst_valid_o, pc_fo, inst_fo);
    end
  endtask

  task automatic test_stall();
    do_reset(); gnt = 1'b1; rsp_en = 1'b1; nop = 1'b1;
    tick(); tick(); tick();
    n_chk++;
    if (inst_valid_o !== 1'b1 || pc_fo !== 32'h0 || ibus_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_c4: v=%b pc=%h req=%b exp 1/0/0", inst_valid_o, pc_fo, ibus_req_o);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (inst_valid_o !== 1'b1 || pc_fo !== 32'h0 || inst_fo !== 32'hFFFF_FFFF ||
          ibus_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: v=%b pc=%h inst=%h req=%b exp 1/0/ffffffff/0",
                 i, inst_valid_o, pc_fo, inst_fo, ibus_req_o);
      end
      tick();
    end
    nop = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    n_chk++;
    if (perf_stall !== 32'd6 || perf_fetch !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_perf: stall=%0d fetch=%0d exp 6/0", perf_stall, perf_fetch);
    end
`endif
    n_chk++;
    if (pc_fo !== 32'h0 || ibus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_rel: pc=%h req=%b exp 0/0", pc_fo, ibus_req_o);
    end
    tick();
    n_chk++;
    if (pc_fo !== 32'h4 || inst_fo !== 32'hFFFF_FFFB || ibus_req_o !== 1'b1 ||
        ibus_addr_o !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_resume: pc=%h inst=%h req=%b addr=%h exp 4/fffffffb/1/8",
               pc_fo, inst_fo, ibus_req_o, ibus_addr_o);
    end
    tick(); tick();
    n_chk++;
    if (inst_valid_o !== 1'b1 || pc_fo !== 32'h8 || inst_fo !== 32'hFFFF_FFF7) begin
      n_fail++;
      $display("FAIL stall_next: v=%b pc=%h inst=%h exp 1/8/fffffff7", inst_valid_o, pc_fo, inst_fo);
    end
`ifdef FETCH_PERF_CNT_EN
    n_chk++;
    if (perf_fetch !== 32'd2) begin
      n_fail++; $display("FAIL stall_fetchcnt: got %0d exp 2", perf_fetch);
    end
`endif
  endtask

  task automatic test_redirect();
    do_reset(); gnt = 1'b1;
    tick(); tick(); tick();
    n_chk++;
    if (ibus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL redir_full: req=%b exp 0", ibus_req_o);
    end
    redir = 1'b1; redir_pc = 32'h0000_1003; rsp_en = 1'b1;
    tick();
    redir = 1'b0;
    n_chk++;
    if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h1000) begin
      n_fail++;
      $display("FAIL redir_c5: v=%b req=%b addr=%h exp 0/0/1000", inst_valid_o, ibus_req_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h1000) begin
      n_fail++;
      $display("FAIL redir_c6: v=%b req=%b addr=%h exp 0/1/1000", inst_valid_o, ibus_req_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b0 || ibus_addr_o !== 32'h1004) begin
      n_fail++; $display("FAIL redir_c7: v=%b addr=%h exp 0/1004", inst_valid_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b1 || pc_fo !== 32'h1000 || inst_fo !== 32'hFFFF_EFFF) begin
      n_fail++;
      $display("FAIL redir_first: v=%b pc=%h inst=%h exp 1/1000/ffffefff", inst_valid_o, pc_fo, inst_fo);
    end
  endtask

  task automatic test_redir_collide();
    do_reset(); gnt = 1'b1; rsp_en = 1'b1;
    tick(); tick();
    redir = 1'b1; redir_pc = 32'h0000_0200;
    tick();
    redir = 1'b0;
    n_chk++;
    if (inst_valid_o !== 1'b0 || inst_fo !== 32'h13 || ibus_req_o !== 1'b1 ||
        ibus_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL coll_c4: v=%b inst=%h req=%b addr=%h exp 0/13/1/200",
               inst_valid_o, inst_fo, ibus_req_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b0 || ibus_addr_o !== 32'h204) begin
      n_fail++; $display("FAIL coll_c5: v=%b addr=%h exp 0/204", inst_valid_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b1 || pc_fo !== 32'h200 || inst_fo !== 32'hFFFF_FDFF) begin
      n_fail++;
      $display("FAIL coll_first: v=%b pc=%h inst=%h exp 1/200/fffffdff", inst_valid_o, pc_fo, inst_fo);
    end
  endtask

  task automatic test_wrap();
    do_reset(); gnt = 1'b1; rsp_en = 1'b1;
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir = 1'b0;
    n_chk++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_a0: req=%b addr=%h exp 1/fffffffc", ibus_req_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL wrap_a1: req=%b addr=%h exp 1/0", ibus_req_o, ibus_addr_o);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b1 || pc_fo !== 32'hFFFF_FFFC || inst_fo !== 32'h3) begin
      n_fail++;
      $display("FAIL wrap_i0: v=%b pc=%h inst=%h exp 1/fffffffc/3", inst_valid_o, pc_fo, inst_fo);
    end
    tick();
    n_chk++;
    if (inst_valid_o !== 1'b1 || pc_fo !== 32'h0 || inst_fo !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_i1: v=%b pc=%h inst=%h exp 1/0/ffffffff", inst_valid_o, pc_fo, inst_fo);
    end
  endtask

  task automatic test_reset_drain();
    do_reset(); gnt = 1'b1;
    tick(); tick(); tick();
    rsp_en = 1'b1;
    tick(); tick(); tick();
    rsp_en = 1'b0;
    tick(); tick();
    redir = 1'b1; redir_pc = 32'h0000_0080;
    tick();
    redir = 1'b0;
    n_chk++;
    if (inst_valid_o !== 1'b0 || pc_fo !== 32'h4 || inst_fo !== 32'h13 ||
        ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h80) begin
      n_fail++;
      $display("FAIL drain_state: v=%b pc=%h inst=%h req=%b addr=%h exp 0/4/13/0/80",
               inst_valid_o, pc_fo, inst_fo, ibus_req_o, ibus_addr_o);
    end
`ifdef FETCH_PERF_CNT_EN
    n_chk++;
    if (perf_fetch !== 32'd2) begin
      n_fail++; $display("FAIL drain_perf: fetch=%0d exp 2", perf_fetch);
    end
`endif
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (inst_valid_o !== 1'b0 || pc_fo !== 32'h0 || inst_fo !== 32'h13 ||
        ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL drain_rst: v=%b pc=%h inst=%h req=%b addr=%h exp 0/0/13/0/0",
               inst_valid_o, pc_fo, inst_fo, ibus_req_o, ibus_addr_o);
    end
`ifdef FETCH_PERF_CNT_EN
    n_chk++;
    if (perf_fetch !== 32'd0 || perf_stall !== 32'd0) begin
      n_fail++; $display("FAIL drain_rst_perf: got %0d/%0d exp 0/0", perf_fetch, perf_stall);
    end
`endif
    q.delete();
    rvalid = 1'b0;
    rdata  = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redir_collide();
    test_wrap();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
